// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: circular byte FIFO feeding a frame FSM with
// a baud-rate bit timer. tx idles high and sends data LSB first.
module uart_tx_fifo #(
  parameter int SIM             = 0,
  parameter int SYS_CLK_FREQ    = 100000000,
  parameter int BAUD_RATE       = 115200,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CLKS_PER_BIT = (SIM != 0) ? 4 : SYS_CLK_FREQ / BAUD_RATE;
  localparam int unsigned TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned AW    = FIFO_DEPTH_LOG2;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [TW-1:0] TMR_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMR_INC   = TW'(1);
  localparam logic [AW-1:0] PTR_INC   = AW'(1);
  localparam logic [AW:0]   CNT_INC   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_ok, pop;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          par, par_next;
  logic          bit_end;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign bit_end = (timer == TMR_LAST);
  assign busy    = (state != IDLE);

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_INC;
      if (pop)   rd_ptr <= rd_ptr + PTR_INC;
      case ({wr_ok, pop})
        2'b10:   count <= count + CNT_INC;
        2'b01:   count <= count - CNT_INC;
        default: count <= count;
      endcase
    end
  end

  // Frame FSM and bit datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      idx   <= idx_next;
      shift <= shift_next;
      par   <= par_next;
    end
  end

  // Next-state, FIFO pop and serial output decode
  always_comb begin
    state_next = state;
    timer_next = timer;
    idx_next   = idx;
    shift_next = shift;
    par_next   = par;
    pop        = 1'b0;
    tx         = 1'b1;
    if (state != IDLE) timer_next = bit_end ? '0 : timer + TMR_INC;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          timer_next = '0;
          idx_next   = '0;
          par_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx = shift[0];
        if (bit_end) begin
          shift_next = {1'b0, shift[7:1]};
          par_next   = par ^ shift[0];
          idx_next   = idx + 3'd1;
          if (idx == 3'd7) begin
            idx_next   = '0;
            state_next = (PARITY_MODE != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        tx = (PARITY_MODE == 2) ? par : ~par;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          if (idx == LAST_STOP) begin
            // Chain straight into the next frame when data is waiting
            if (!empty) begin
              pop        = 1'b1;
              shift_next = mem[rd_ptr];
              idx_next   = '0;
              par_next   = 1'b0;
              state_next = START;
            end else begin
              idx_next   = '0;
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: five configurations, scoreboard of written
// bytes checked against frames decoded from each tx line.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_v    [5];
  logic       tx_v    [5];
  logic       busy_v  [5];
  logic       empty_v [5];
  logic       full_v  [5];

  int cpb_t [5] = '{4, 4, 4, 4, 868};
  int pm_t  [5] = '{0, 2, 1, 0, 0};
  int sb_t  [5] = '{1, 1, 1, 2, 1};

  int vectors = 0;
  int miscompares = 0;
  int busy_cnt;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.SIM(1), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_v[0]), .wr_data(wr_data),
    .full(full_v[0]), .empty(empty_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
  uart_tx_fifo #(.SIM(1), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_v[1]), .wr_data(wr_data),
    .full(full_v[1]), .empty(empty_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
  uart_tx_fifo #(.SIM(1), .PARITY_MODE(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_v[2]), .wr_data(wr_data),
    .full(full_v[2]), .empty(empty_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
  uart_tx_fifo #(.SIM(1), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_v[3]), .wr_data(wr_data),
    .full(full_v[3]), .empty(empty_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));
  uart_tx_fifo #(.SIM(0), .PARITY_MODE(0), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst), .wr_en(wr_v[4]), .wr_data(wr_data),
    .full(full_v[4]), .empty(empty_v[4]), .busy(busy_v[4]), .tx(tx_v[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Write one byte; push to the scoreboard only if it should be accepted
  task automatic put(input int k, input logic [7:0] d, input bit accept);
    wr_v[k] = 1'b1;
    wr_data = d;
    if (accept) sb.push_back(d);
    @(negedge clk);
    wr_v[k] = 1'b0;
  endtask

  // Sample one bit period starting at the current negedge
  task automatic get_bit(input int k, output logic v, output logic ok);
    v  = tx_v[k];
    ok = 1'b1;
    for (int i = 0; i < cpb_t[k]; i++) begin
      if (tx_v[k] !== v) ok = 1'b0;
      if (busy_v[k] === 1'b1) busy_cnt++;
      @(negedge clk);
    end
  endtask

  // Decode one frame; exp_gap < 0 skips the idle-gap check
  task automatic rx_frame(input int k, input int exp_gap);
    int n;
    logic v, ok, all_ok;
    logic [7:0] b, e;
    int p;
    n = 0;
    while (tx_v[k] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", {31'd0, tx_v[k]}, 32'd0);
    if (tx_v[k] !== 1'b0) return;
    if (exp_gap >= 0) check("gap", n, exp_gap);
    busy_cnt = 0;
    get_bit(k, v, ok);
    check("start_bit", {30'd0, ok, v}, 32'd2);
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_bit(k, v, ok);
      b[i] = v;
      all_ok &= ok;
    end
    check("data_stable", {31'd0, all_ok}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      e = b;
    end else begin
      e = sb.pop_front();
      check("data", {24'd0, b}, {24'd0, e});
    end
    p = (pm_t[k] != 0) ? 1 : 0;
    if (p == 1) begin
      get_bit(k, v, ok);
      check("parity", {30'd0, ok, v}, {30'd0, 1'b1, (pm_t[k] == 2) ? ^e : ~^e});
    end
    all_ok = 1'b1;
    for (int s = 0; s < sb_t[k]; s++) begin
      get_bit(k, v, ok);
      all_ok &= ok & v;
    end
    check("stop", {31'd0, all_ok}, 32'd1);
    check("busy_len", busy_cnt, cpb_t[k] * (9 + p + sb_t[k]));
  endtask

  initial begin
    int lows, highs;
    for (int i = 0; i < 5; i++) wr_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx",    {31'd0, tx_v[0]},    32'd1);
    check("rst_busy",  {31'd0, busy_v[0]},  32'd0);
    check("rst_empty", {31'd0, empty_v[0]}, 32'd1);
    check("rst_full",  {31'd0, full_v[0]},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame 0x55
    put(0, 8'h55, 1'b1);
    check("lat_empty", {31'd0, empty_v[0]}, 32'd0);
    check("lat_tx",    {31'd0, tx_v[0]},    32'd1);
    rx_frame(0, 1);
    check("end_tx",    {31'd0, tx_v[0]},    32'd1);
    check("end_busy",  {31'd0, busy_v[0]},  32'd0);
    check("end_empty", {31'd0, empty_v[0]}, 32'd1);

    // Parity even then odd on 0x07
    put(1, 8'h07, 1'b1);
    rx_frame(1, 1);
    put(2, 8'h07, 1'b1);
    rx_frame(2, 1);

    // Odd parity, random bytes back to back
    fork
      begin
        for (int i = 0; i < 3; i++) put(2, 8'($urandom_range(0, 255)), 1'b1);
      end
      begin
        rx_frame(2, -1);
        rx_frame(2, 0);
        rx_frame(2, 0);
      end
    join
    check("rnd_busy", {31'd0, busy_v[2]}, 32'd0);

    // Two stop bits
    put(3, 8'hA3, 1'b1);
    rx_frame(3, 1);

    // Overflow: 10 writes, 0x09 dropped, 9 contiguous frames
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          put(0, 8'(i), i < 9);
          if (i == 7) check("full_pre", {31'd0, full_v[0]}, 32'd0);
          if (i == 8) check("full_set", {31'd0, full_v[0]}, 32'd1);
        end
      end
      begin
        rx_frame(0, -1);
        check("full_clr", {31'd0, full_v[0]}, 32'd0);
        for (int f = 1; f < 9; f++) begin
          check("b2b_busy", {31'd0, busy_v[0]}, 32'd1);
          rx_frame(0, 0);
        end
      end
    join
    check("ovf_busy",  {31'd0, busy_v[0]},  32'd0);
    check("ovf_empty", {31'd0, empty_v[0]}, 32'd1);
    check("ovf_sb",    sb.size(),           32'd0);

    // Reset during data bit 3 with two bytes queued
    put(0, 8'h3C, 1'b0);
    put(0, 8'h11, 1'b0);
    put(0, 8'h22, 1'b0);
    repeat (16) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy_v[0]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_tx",    {31'd0, tx_v[0]},    32'd1);
    check("mrst_busy",  {31'd0, busy_v[0]},  32'd0);
    check("mrst_empty", {31'd0, empty_v[0]}, 32'd1);
    rst = 1'b0;
    lows = 0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) lows++;
      if (busy_v[0] !== 1'b0) highs++;
    end
    check("post_rst_tx",   lows,  32'd0);
    check("post_rst_busy", highs, 32'd0);
    put(0, 8'h96, 1'b1);
    rx_frame(0, 1);

    // Default divider: 868 clocks per bit
    put(4, 8'hA5, 1'b1);
    rx_frame(4, 1);
    check("div_busy", {31'd0, busy_v[4]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
